// File: rtl/load_store_unit_if.sv
// Request/response and data-memory bus of the load/store unit.
// master = execute stage plus data memory; slave = the load/store unit.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic        resp_err;
  logic [31:0] resp_rdata;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic [31:0] mem_rdata;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_we
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_err, resp_rdata, mem_addr, mem_wdata, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Multi-cycle byte/half/word load-store unit over a word-addressed data memory,
// splitting word-boundary-crossing accesses into two word accesses.
module load_store_unit #(
  parameter bit ALLOW_MISALIGNED = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  load_store_unit_if.slave bus
);

  localparam logic [3:0] IDLE = 4'd0;
  localparam logic [3:0] LD0  = 4'd1;
  localparam logic [3:0] LD1  = 4'd2;
  localparam logic [3:0] RD0  = 4'd3;
  localparam logic [3:0] WR0  = 4'd4;
  localparam logic [3:0] RD1  = 4'd5;
  localparam logic [3:0] WR1  = 4'd6;
  localparam logic [3:0] RESP = 4'd7;
  localparam logic [3:0] ERR  = 4'd8;

  logic [3:0]  state;
  logic        op_we;
  logic [2:0]  op_f3;
  logic [31:0] op_addr;
  logic [31:0] op_wdata;
  logic [31:0] buf0;
  logic [31:0] buf1;

  function automatic logic [2:0] size_of(input logic [1:0] f);
    case (f)
      2'b00:   size_of = 3'd1;
      2'b01:   size_of = 3'd2;
      default: size_of = 3'd4;
    endcase
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old_word,
                                        input logic [31:0] new_word,
                                        input logic [3:0]  mask);
    for (int k = 0; k < 4; k++)
      merge[8*k +: 8] = mask[k] ? new_word[8*k +: 8] : old_word[8*k +: 8];
  endfunction

  logic [2:0] req_n;
  logic       req_illegal;
  logic       req_misal;
  logic       req_err;
  logic       req_full_sw;

  always_comb begin
    req_n       = size_of(bus.req_funct3[1:0]);
    req_illegal = bus.req_we ? (bus.req_funct3[2] || bus.req_funct3[1:0] == 2'b11)
                             : (bus.req_funct3 == 3'b011 || bus.req_funct3 == 3'b110 ||
                                bus.req_funct3 == 3'b111);
    req_misal   = |(bus.req_addr[1:0] & 2'(req_n - 3'd1));
    req_err     = req_illegal || (!ALLOW_MISALIGNED && req_misal);
    req_full_sw = bus.req_funct3[1:0] == 2'b10 && bus.req_addr[1:0] == 2'b00;
  end

  logic [2:0]  n;
  logic [1:0]  off;
  logic [5:0]  sh;
  logic        crossing;
  logic        full_sw;
  logic [31:0] a0;
  logic [31:0] a1;
  logic [3:0]  nmask;
  logic [7:0]  bmask;
  logic [31:0] wmasked;
  logic [63:0] wide_data;
  logic [31:0] ld_word;
  logic [31:0] ld_result;
  logic        sx;

  // Byte lanes of the access laid out across the two words {A1, A0}.
  always_comb begin
    n        = size_of(op_f3[1:0]);
    off      = op_addr[1:0];
    sh       = {1'b0, off, 3'b000};
    crossing = ({2'b00, off} + {1'b0, n}) > 4'd4;
    full_sw  = op_f3[1:0] == 2'b10 && off == 2'b00;
    a0       = {op_addr[31:2], 2'b00};
    a1       = a0 + 32'd4;
    case (n)
      3'd1:    begin nmask = 4'b0001; wmasked = {24'd0, op_wdata[7:0]};  end
      3'd2:    begin nmask = 4'b0011; wmasked = {16'd0, op_wdata[15:0]}; end
      default: begin nmask = 4'b1111; wmasked = op_wdata;                end
    endcase
    bmask     = {4'b0000, nmask} << off;
    wide_data = {32'd0, wmasked} << sh;
    ld_word   = 32'({buf1, buf0} >> sh);
    sx        = ~op_f3[2];
    case (op_f3[1:0])
      2'b00:   ld_result = {{24{sx & ld_word[7]}}, ld_word[7:0]};
      2'b01:   ld_result = {{16{sx & ld_word[15]}}, ld_word[15:0]};
      default: ld_result = ld_word;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      op_we    <= 1'b0;
      op_f3    <= 3'd0;
      op_addr  <= 32'd0;
      op_wdata <= 32'd0;
      buf0     <= 32'd0;
      buf1     <= 32'd0;
    end else begin
      case (state)
        IDLE: if (bus.req_valid) begin
          op_we    <= bus.req_we;
          op_f3    <= bus.req_funct3;
          op_addr  <= bus.req_addr;
          op_wdata <= bus.req_wdata;
          buf0     <= 32'd0;
          buf1     <= 32'd0;
          if (req_err)          state <= ERR;
          else if (!bus.req_we) state <= LD0;
          else if (req_full_sw) state <= WR0;
          else                  state <= RD0;
        end
        LD0: begin
          buf0  <= bus.mem_rdata;
          state <= crossing ? LD1 : RESP;
        end
        LD1: begin
          buf1  <= bus.mem_rdata;
          state <= RESP;
        end
        RD0: begin
          buf0  <= merge(bus.mem_rdata, wide_data[31:0], bmask[3:0]);
          state <= WR0;
        end
        WR0: state <= crossing ? RD1 : RESP;
        RD1: begin
          buf1  <= merge(bus.mem_rdata, wide_data[63:32], bmask[7:4]);
          state <= WR1;
        end
        WR1:     state <= RESP;
        default: state <= IDLE;
      endcase
    end
  end

  // Memory and response outputs are purely decoded from state so reset drops them at once.
  always_comb begin
    bus.req_ready  = (state == IDLE);
    bus.resp_valid = 1'b0;
    bus.resp_err   = 1'b0;
    bus.resp_rdata = 32'd0;
    bus.mem_addr   = 32'd0;
    bus.mem_wdata  = 32'd0;
    bus.mem_we     = 1'b0;
    case (state)
      LD0, RD0: bus.mem_addr = a0;
      LD1, RD1: bus.mem_addr = a1;
      WR0: begin
        bus.mem_addr  = a0;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = full_sw ? op_wdata : buf0;
      end
      WR1: begin
        bus.mem_addr  = a1;
        bus.mem_we    = 1'b1;
        bus.mem_wdata = buf1;
      end
      RESP: begin
        bus.resp_valid = 1'b1;
        bus.resp_rdata = op_we ? 32'd0 : ld_result;
      end
      ERR: begin
        bus.resp_valid = 1'b1;
        bus.resp_err   = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Directed-vector bench for load_store_unit: one DUT with misaligned splitting,
// one with it disabled, plus a small word memory model behind the first.
module tb_load_store_unit;

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  load_store_unit_if bus1();
  load_store_unit_if bus0();

  load_store_unit #(.ALLOW_MISALIGNED(1'b1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1));
  load_store_unit #(.ALLOW_MISALIGNED(1'b0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(bus0));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // 256-word window indexed by address bits [9:2]; writes to address 0 are dropped.
  logic [31:0] mem [0:255];
  logic        pre_we;
  logic [7:0]  pre_idx;
  logic [31:0] pre_data;

  assign bus1.mem_rdata = mem[bus1.mem_addr[9:2]];
  assign bus0.mem_rdata = 32'h0;

  always @(posedge clk) begin
    if (pre_we) mem[pre_idx] <= pre_data;
    else if (bus1.mem_we && bus1.mem_addr != 32'h0) mem[bus1.mem_addr[9:2]] <= bus1.mem_wdata;
  end

  task automatic poke(input logic [31:0] addr, input logic [31:0] data);
    pre_idx  = addr[9:2];
    pre_data = data;
    pre_we   = 1'b1;
    @(negedge clk);
    pre_we   = 1'b0;
  endtask

  // Issues one request and reports latency (cycles after the accept cycle), result,
  // number of mem_we cycles and mem_addr of the second busy cycle. lat = -1 on timeout.
  task automatic issue(input bit sel, input logic we, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       output int lat, output logic [31:0] rdata, output logic err,
                       output int we_cnt, output logic [31:0] addr2);
    int guard;
    logic v, e, w;
    logic [31:0] d, a;
    lat = -1; rdata = '0; err = 1'b0; we_cnt = 0; addr2 = '0; guard = 0;
    while (!(sel ? bus1.req_ready : bus0.req_ready) && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (sel) begin
      bus1.req_valid = 1'b1; bus1.req_we = we; bus1.req_funct3 = f3;
      bus1.req_addr = addr; bus1.req_wdata = wdata;
    end else begin
      bus0.req_valid = 1'b1; bus0.req_we = we; bus0.req_funct3 = f3;
      bus0.req_addr = addr; bus0.req_wdata = wdata;
    end
    @(negedge clk);
    bus1.req_valid = 1'b0;
    bus0.req_valid = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      if (i > 1) @(negedge clk);
      v = sel ? bus1.resp_valid : bus0.resp_valid;
      e = sel ? bus1.resp_err   : bus0.resp_err;
      d = sel ? bus1.resp_rdata : bus0.resp_rdata;
      w = sel ? bus1.mem_we     : bus0.mem_we;
      a = sel ? bus1.mem_addr   : bus0.mem_addr;
      if (w) we_cnt++;
      if (i == 2) addr2 = a;
      if (v) begin
        lat = i; rdata = d; err = e;
        break;
      end
    end
  endtask

  int          lat;
  logic [31:0] rdata;
  logic        err;
  int          we_cnt;
  logic [31:0] addr2;

  task automatic test_reset;
    checks++; if (bus1.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL rst_ready got=%b exp=1", bus1.req_ready); end
    checks++; if (bus1.resp_valid !== 1'b0) begin failures++; $display("[TB] FAIL rst_resp_valid got=%b exp=0", bus1.resp_valid); end
    checks++; if (bus1.resp_rdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_rdata got=%h exp=0", bus1.resp_rdata); end
    checks++; if (bus1.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL rst_mem_we got=%b exp=0", bus1.mem_we); end
    checks++; if (bus1.mem_addr !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_addr got=%h exp=0", bus1.mem_addr); end
    checks++; if (bus1.mem_wdata !== 32'h0) begin failures++; $display("[TB] FAIL rst_mem_wdata got=%h exp=0", bus1.mem_wdata); end
  endtask

  task automatic test_aligned_lw;
    poke(32'h100, 32'hDEADBEEF);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL lw_data got=%h exp=deadbeef", rdata); end
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL lw_latency got=%0d exp=2", lat); end
    checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL lw_err got=%b exp=0", err); end
  endtask

  task automatic test_sub_word_loads;
    poke(32'h100, 32'h80FF7F01);
    issue(1'b1, 1'b0, 3'b000, 32'h103, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'hFFFFFF80) begin failures++; $display("[TB] FAIL lb_data got=%h exp=ffffff80", rdata); end
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL lb_latency got=%0d exp=2", lat); end
    issue(1'b1, 1'b0, 3'b100, 32'h103, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'h00000080) begin failures++; $display("[TB] FAIL lbu_data got=%h exp=00000080", rdata); end
    issue(1'b1, 1'b0, 3'b101, 32'h101, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'h0000FF7F) begin failures++; $display("[TB] FAIL lhu_data got=%h exp=0000ff7f", rdata); end
    issue(1'b1, 1'b0, 3'b001, 32'h102, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'hFFFF80FF) begin failures++; $display("[TB] FAIL lh_data got=%h exp=ffff80ff", rdata); end
  endtask

  task automatic test_crossing_store;
    poke(32'h200, 32'h11223344);
    poke(32'h204, 32'h55667788);
    issue(1'b1, 1'b1, 3'b001, 32'h203, 32'h0000ABCD, lat, rdata, err, we_cnt, addr2);
    checks++; if (lat !== 5) begin failures++; $display("[TB] FAIL sh_cross_latency got=%0d exp=5", lat); end
    checks++; if (we_cnt !== 2) begin failures++; $display("[TB] FAIL sh_cross_writes got=%0d exp=2", we_cnt); end
    checks++; if (mem[8'h80] !== 32'hCD223344) begin failures++; $display("[TB] FAIL sh_cross_w0 got=%h exp=cd223344", mem[8'h80]); end
    checks++; if (mem[8'h81] !== 32'h556677AB) begin failures++; $display("[TB] FAIL sh_cross_w1 got=%h exp=556677ab", mem[8'h81]); end
    issue(1'b1, 1'b0, 3'b001, 32'h203, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'hFFFFABCD) begin failures++; $display("[TB] FAIL lh_cross_data got=%h exp=ffffabcd", rdata); end
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL lh_cross_latency got=%0d exp=3", lat); end
  endtask

  task automatic test_aligned_stores;
    issue(1'b1, 1'b1, 3'b010, 32'h104, 32'hCAFEF00D, lat, rdata, err, we_cnt, addr2);
    checks++; if (lat !== 2) begin failures++; $display("[TB] FAIL sw_latency got=%0d exp=2", lat); end
    checks++; if (we_cnt !== 1) begin failures++; $display("[TB] FAIL sw_writes got=%0d exp=1", we_cnt); end
    checks++; if (rdata !== 32'h0) begin failures++; $display("[TB] FAIL sw_rdata got=%h exp=0", rdata); end
    checks++; if (mem[8'h41] !== 32'hCAFEF00D) begin failures++; $display("[TB] FAIL sw_word got=%h exp=cafef00d", mem[8'h41]); end
    issue(1'b1, 1'b1, 3'b000, 32'h101, 32'h12345655, lat, rdata, err, we_cnt, addr2);
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL sb_latency got=%0d exp=3", lat); end
    checks++; if (mem[8'h40] !== 32'h80FF5501) begin failures++; $display("[TB] FAIL sb_word got=%h exp=80ff5501", mem[8'h40]); end
  endtask

  task automatic test_wrap;
    poke(32'hFFFFFFFC, 32'h12345678);
    poke(32'h0, 32'hAABBCCDD);
    issue(1'b1, 1'b0, 3'b010, 32'hFFFFFFFE, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'hCCDD1234) begin failures++; $display("[TB] FAIL wrap_data got=%h exp=ccdd1234", rdata); end
    checks++; if (lat !== 3) begin failures++; $display("[TB] FAIL wrap_latency got=%0d exp=3", lat); end
    checks++; if (addr2 !== 32'h0) begin failures++; $display("[TB] FAIL wrap_addr got=%h exp=0", addr2); end
  endtask

  task automatic test_errors;
    issue(1'b0, 1'b1, 3'b010, 32'h102, 32'h12345678, lat, rdata, err, we_cnt, addr2);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL misal_sw_err got=%b exp=1", err); end
    checks++; if (lat !== 1) begin failures++; $display("[TB] FAIL misal_sw_latency got=%0d exp=1", lat); end
    checks++; if (we_cnt !== 0) begin failures++; $display("[TB] FAIL misal_sw_writes got=%0d exp=0", we_cnt); end
    issue(1'b0, 1'b0, 3'b011, 32'h100, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL ld011_err got=%b exp=1", err); end
    issue(1'b0, 1'b0, 3'b001, 32'h102, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (err !== 1'b0 || lat !== 2) begin failures++; $display("[TB] FAIL aligned_lh_noerr got=%b/%0d exp=0/2", err, lat); end
    issue(1'b0, 1'b0, 3'b010, 32'h101, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL misal_lw_err got=%b exp=1", err); end
    issue(1'b1, 1'b1, 3'b100, 32'h100, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (err !== 1'b1 || we_cnt !== 0) begin failures++; $display("[TB] FAIL st100_err got=%b/%0d exp=1/0", err, we_cnt); end
    issue(1'b1, 1'b0, 3'b110, 32'h100, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (err !== 1'b1 || rdata !== 32'h0) begin failures++; $display("[TB] FAIL ld110_err got=%b/%h exp=1/0", err, rdata); end
  endtask

  task automatic test_back_to_back;
    int resp_cnt;
    resp_cnt = 0;
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b0; bus1.req_funct3 = 3'b010;
    bus1.req_addr = 32'h104; bus1.req_wdata = 32'h0;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (i == 3) bus1.req_valid = 1'b0;
      if (bus1.resp_valid) resp_cnt++;
    end
    checks++; if (resp_cnt !== 1) begin failures++; $display("[TB] FAIL busy_ignored got=%0d exp=1", resp_cnt); end
    issue(1'b1, 1'b0, 3'b010, 32'h104, 32'h0, lat, rdata, err, we_cnt, addr2);
    issue(1'b1, 1'b0, 3'b010, 32'h100, 32'h0, lat, rdata, err, we_cnt, addr2);
    checks++; if (rdata !== 32'h80FF5501 || lat !== 2) begin failures++; $display("[TB] FAIL b2b_lw got=%h/%0d exp=80ff5501/2", rdata, lat); end
  endtask

  task automatic test_reset_mid_store;
    int resp_cnt;
    resp_cnt = 0;
    poke(32'h20C, 32'hAAAAAAAA);
    poke(32'h210, 32'hBBBBBBBB);
    @(negedge clk);
    bus1.req_valid = 1'b1; bus1.req_we = 1'b1; bus1.req_funct3 = 3'b010;
    bus1.req_addr = 32'h20E; bus1.req_wdata = 32'h11223344;
    @(negedge clk);
    bus1.req_valid = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (bus1.mem_we !== 1'b1 || bus1.mem_addr !== 32'h210) begin failures++; $display("[TB] FAIL wr1_reached got=%b/%h exp=1/00000210", bus1.mem_we, bus1.mem_addr); end
    rst_n = 1'b0;
    #1;
    checks++; if (bus1.mem_we !== 1'b0) begin failures++; $display("[TB] FAIL abort_mem_we got=%b exp=0", bus1.mem_we); end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) rst_n = 1'b1;
      if (bus1.resp_valid) resp_cnt++;
    end
    checks++; if (resp_cnt !== 0) begin failures++; $display("[TB] FAIL abort_no_resp got=%0d exp=0", resp_cnt); end
    checks++; if (bus1.req_ready !== 1'b1) begin failures++; $display("[TB] FAIL abort_ready got=%b exp=1", bus1.req_ready); end
    checks++; if (mem[8'h84] !== 32'hBBBBBBBB) begin failures++; $display("[TB] FAIL abort_a1 got=%h exp=bbbbbbbb", mem[8'h84]); end
    checks++; if (mem[8'h83] !== 32'h3344AAAA) begin failures++; $display("[TB] FAIL abort_a0 got=%h exp=3344aaaa", mem[8'h83]); end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    rst_n = 1'b0;
    pre_we = 1'b0; pre_idx = '0; pre_data = '0;
    bus1.req_valid = 1'b0; bus1.req_we = 1'b0; bus1.req_funct3 = '0;
    bus1.req_addr = '0; bus1.req_wdata = '0;
    bus0.req_valid = 1'b0; bus0.req_we = 1'b0; bus0.req_funct3 = '0;
    bus0.req_addr = '0; bus0.req_wdata = '0;
    repeat (2) @(negedge clk);
    test_reset;
    rst_n = 1'b1;
    @(negedge clk);
    test_aligned_lw;
    test_sub_word_loads;
    test_crossing_store;
    test_aligned_stores;
    test_wrap;
    test_errors;
    test_back_to_back;
    test_reset_mid_store;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
